escalonador_ctx: RTL and testbench

//  Preemptive round-robin context-switch initiator for the OS layer. It counts a time quantum,

---
 rtl/escalonador_ctx.sv | 148 ++++++++++++++
 tb/tb_escalonador_ctx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/escalonador_ctx.sv
// Round-robin context-switch initiator: quantum/yield trigger, PC save/restore through the
// context table, then a set_ctx/pc_load pulse with the next pid. Dormant while BIOS runs.
module escalonador_ctx #(
  parameter int PID_W = 2,
  parameter int QUANTUM = 1000,
  parameter int CNT_W = 16,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] CTX_BASE = 32'h00000F00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bios_mode,
  input  logic [PID_W-1:0]      id_proc,
  input  logic                  yield,
  input  logic [(1<<PID_W)-1:0] proc_ready,
  input  logic [ADDR_W-1:0]     pc_cur,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [ADDR_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [ADDR_W-1:0]     mem_rdata,
  output logic                  pc_load,
  output logic [ADDR_W-1:0]     pc_restore,
  output logic                  set_ctx,
  output logic [PID_W-1:0]      id_proc_atual
);

  localparam int NPROC = 1 << PID_W;

  // state  | meaning
  // RUN    | user code running, quantum counting (held at 0 in BIOS)
  // PICK   | choose next ready pid after id_proc
  // SAVE   | write pc_cur to table entry of id_proc
  // GAP    | mandatory idle cycle between the two requests
  // LOAD   | read table entry of nxt
  // COMMIT | pulse set_ctx/pc_load with the restored PC
  typedef enum logic [2:0] {RUN, PICK, SAVE, GAP, LOAD, COMMIT} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [PID_W-1:0]   nxt;
  logic               found;
  logic [PID_W-1:0]   pick_pid;
  logic [PID_W-1:0]   cand;
  logic               trigger;

  function automatic logic [ADDR_W-1:0] ctx_addr(input logic [PID_W-1:0] pid);
    return CTX_BASE + (ADDR_W'(pid) << 2);
  endfunction

  // Descending scan so the nearest successor (smallest offset) wins.
  always_comb begin
    found = 1'b0;
    pick_pid = '0;
    cand = '0;
    for (int k = NPROC - 1; k >= 1; k--) begin
      cand = id_proc + PID_W'(k);
      if (proc_ready[cand]) begin
        found = 1'b1;
        pick_pid = cand;
      end
    end
  end

  assign trigger = !bios_mode && (cnt == CNT_W'(QUANTUM - 1) || yield);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt <= '0;
      nxt <= '0;
      stall <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      pc_load <= 1'b0;
      pc_restore <= '0;
      set_ctx <= 1'b0;
      id_proc_atual <= '0;
    end else begin
      case (state)
        RUN: begin
          if (bios_mode) begin
            cnt <= '0;
          end else if (trigger) begin
            cnt <= '0;
            stall <= 1'b1;
            state <= PICK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PICK: begin
          if (found) begin
            nxt <= pick_pid;
            mem_req <= 1'b1;
            mem_we <= 1'b1;
            mem_addr <= ctx_addr(id_proc);
            mem_wdata <= pc_cur;
            state <= SAVE;
          end else begin
            stall <= 1'b0;
            state <= RUN;
          end
        end
        SAVE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            state <= GAP;
          end
        end
        GAP: begin
          mem_req <= 1'b1;
          mem_we <= 1'b0;
          mem_addr <= ctx_addr(nxt);
          state <= LOAD;
        end
        LOAD: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            pc_restore <= mem_rdata;
            pc_load <= 1'b1;
            set_ctx <= 1'b1;
            id_proc_atual <= nxt;
            state <= COMMIT;
          end
        end
        COMMIT: begin
          pc_load <= 1'b0;
          set_ctx <= 1'b0;
          stall <= 1'b0;
          cnt <= '0;
          state <= RUN;
        end
        default: begin
          stall <= 1'b0;
          mem_req <= 1'b0;
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_escalonador_ctx.sv
// Scoreboard bench for escalonador_ctx with QUANTUM=8 and a configurable-latency memory model.
module tb_escalonador_ctx;

  logic        clk = 1'b0;
  logic        reset;
  logic        bios_mode;
  logic [1:0]  id_proc;
  logic        yield;
  logic [3:0]  proc_ready;
  logic [31:0] pc_cur;
  logic        stall, mem_req, mem_we, mem_ack, pc_load, set_ctx;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_restore;
  logic [1:0]  id_proc_atual;

  escalonador_ctx #(.PID_W(2), .QUANTUM(8), .CNT_W(16), .ADDR_W(32), .CTX_BASE(32'h00000F00)) dut (
    .clk(clk), .reset(reset), .bios_mode(bios_mode), .id_proc(id_proc), .yield(yield),
    .proc_ready(proc_ready), .pc_cur(pc_cur), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .pc_load(pc_load), .pc_restore(pc_restore), .set_ctx(set_ctx), .id_proc_atual(id_proc_atual)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } mem_txn_t;
  typedef struct { logic [1:0] pid; logic [31:0] pc; } commit_t;
  mem_txn_t mem_q[$];
  commit_t  commit_q[$];

  int checks = 0;
  int failures = 0;
  int ack_lat = 0;
  int wait_cnt = 0;
  int wr_cnt = 0, rd_cnt = 0, commit_cnt = 0, stall_hi = 0;
  int run_len = 0, last_run = 0;
  logic        prev_pend = 1'b0;
  logic        prev_we;
  logic [31:0] prev_addr, prev_wdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] addr);
    return addr + 32'h1234_0000;
  endfunction

  assign mem_rdata = rd_model(mem_addr);
  assign mem_ack = mem_req && (wait_cnt >= ack_lat);

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  // Monitor: memory acceptances, request stability, commits and stall run lengths.
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_pend && mem_req) begin
        chk("hold_we", mem_we, prev_we);
        chk("hold_addr", mem_addr, prev_addr);
        chk("hold_wdata", mem_wdata, prev_wdata);
      end
      if (mem_req) chk("stall_during_req", stall, 1);
      if (mem_req && mem_ack) begin
        if (mem_we) wr_cnt++; else rd_cnt++;
        chk("mem_expected", mem_q.size() != 0, 1);
        if (mem_q.size() != 0) begin
          mem_txn_t t;
          t = mem_q.pop_front();
          chk("mem_we", mem_we, t.we);
          chk("mem_addr", mem_addr, t.addr);
          if (t.we) chk("mem_wdata", mem_wdata, t.data);
        end
      end
      if (set_ctx) begin
        commit_cnt++;
        chk("pc_load_with_set_ctx", pc_load, 1);
        chk("stall_in_commit", stall, 1);
        chk("commit_expected", commit_q.size() != 0, 1);
        if (commit_q.size() != 0) begin
          commit_t c;
          c = commit_q.pop_front();
          chk("id_proc_atual", id_proc_atual, c.pid);
          chk("pc_restore", pc_restore, c.pc);
        end
      end
      if (stall) begin
        stall_hi++;
        run_len++;
      end else if (run_len > 0) begin
        last_run = run_len;
        run_len = 0;
      end
      prev_pend = mem_req && !mem_ack;
      prev_we = mem_we;
      prev_addr = mem_addr;
      prev_wdata = mem_wdata;
    end else begin
      prev_pend = 1'b0;
      run_len = 0;
    end
  end

  task automatic push_switch(input logic [1:0] cur, input logic [1:0] nx, input logic [31:0] pc);
    mem_txn_t t;
    commit_t c;
    t.we = 1'b1; t.addr = 32'hF00 + {28'd0, cur, 2'b00}; t.data = pc;
    mem_q.push_back(t);
    t.we = 1'b0; t.addr = 32'hF00 + {28'd0, nx, 2'b00}; t.data = '0;
    mem_q.push_back(t);
    c.pid = nx; c.pc = rd_model(t.addr);
    commit_q.push_back(c);
  endtask

  // Starts at a point where the DUT is in RUN with counter 0.
  task automatic measure_expiry(input int exp);
    int n = 0;
    bios_mode = 1'b0;
    while (!stall && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("expiry_cycles", n, exp);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (stall && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("idle_reached", stall, 0);
  endtask

  task automatic yield_pulse();
    @(negedge clk);
    bios_mode = 1'b0;
    yield = 1'b1;
    @(negedge clk);
    yield = 1'b0;
  endtask

  initial begin
    int c0, s0, w0, r0, n;
    reset = 1'b1; bios_mode = 1'b1; id_proc = 2'd0; yield = 1'b0;
    proc_ready = 4'b1111; pc_cur = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_pc_load", pc_load, 0);
    chk("rst_pc_restore", pc_restore, 0);
    chk("rst_set_ctx", set_ctx, 0);
    chk("rst_id_atual", id_proc_atual, 0);
    @(negedge clk);
    reset = 1'b0;

    // BIOS dormancy: nothing happens, and the counter restarts from 0 afterwards.
    c0 = commit_cnt; s0 = stall_hi;
    repeat (5000) @(negedge clk);
    chk("bios_no_set_ctx", commit_cnt - c0, 0);
    chk("bios_no_stall", stall_hi - s0, 0);

    // Quantum expiry, pid 0 -> 2, zero-wait memory.
    id_proc = 2'd0; proc_ready = 4'b0101; pc_cur = 32'hCAFE_0100;
    push_switch(2'd0, 2'd2, pc_cur);
    measure_expiry(8);
    wait_idle();
    @(negedge clk); #1;
    chk("zero_wait_switch_len", last_run, 5);
    chk("expiry_commits", commit_cnt - c0, 1);
    chk("expiry_mem_drained", mem_q.size(), 0);
    id_proc = id_proc_atual;
    bios_mode = 1'b1;

    // Yield with pid wrap 3 -> 0.
    repeat (2) @(negedge clk);
    id_proc = 2'd3; proc_ready = 4'b1001; pc_cur = 32'h0000_7A30;
    push_switch(2'd3, 2'd0, pc_cur);
    c0 = commit_cnt;
    yield_pulse();
    wait_idle();
    chk("wrap_commits", commit_cnt - c0, 1);
    chk("wrap_id_held", id_proc_atual, 0);
    bios_mode = 1'b1;

    // Only the current process ready; yield coincident with expiry.
    @(negedge clk);
    id_proc = 2'd1; proc_ready = 4'b0010;
    c0 = commit_cnt; w0 = wr_cnt; r0 = rd_cnt;
    bios_mode = 1'b0;
    repeat (7) @(negedge clk);
    yield = 1'b1;
    @(negedge clk);
    yield = 1'b0;
    #1;
    chk("self_only_pick", stall, 1);
    @(negedge clk); #1;
    chk("self_only_back_run", stall, 0);
    chk("self_only_pick_len", last_run, 1);
    measure_expiry(8);
    wait_idle();
    chk("self_only_no_commit", commit_cnt - c0, 0);
    chk("self_only_no_mem", (wr_cnt - w0) + (rd_cnt - r0), 0);
    bios_mode = 1'b1;

    // Slow memory: 3 extra wait cycles per request.
    @(negedge clk);
    ack_lat = 3;
    id_proc = 2'd2; proc_ready = 4'b1000; pc_cur = 32'h1357_9BDF;
    push_switch(2'd2, 2'd3, pc_cur);
    c0 = commit_cnt; w0 = wr_cnt; r0 = rd_cnt;
    yield_pulse();
    wait_idle();
    chk("slow_writes", wr_cnt - w0, 1);
    chk("slow_reads", rd_cnt - r0, 1);
    chk("slow_commits", commit_cnt - c0, 1);
    bios_mode = 1'b1;

    // Reset while the LOAD request is outstanding.
    @(negedge clk);
    ack_lat = 5;
    id_proc = 2'd0; proc_ready = 4'b0010; pc_cur = 32'h0BAD_F00D;
    begin
      mem_txn_t t;
      t.we = 1'b1; t.addr = 32'hF00; t.data = pc_cur;
      mem_q.push_back(t);
    end
    c0 = commit_cnt;
    yield_pulse();
    n = 0;
    while (!(mem_req && !mem_we) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("load_reached", mem_req && !mem_we, 1);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("rst_mid_mem_req", mem_req, 0);
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_set_ctx", set_ctx, 0);
    reset = 1'b0;
    proc_ready = 4'b0001;
    measure_expiry(8);
    wait_idle();
    chk("rst_mid_no_commit", commit_cnt - c0, 0);
    bios_mode = 1'b1;
    repeat (3) @(negedge clk);

    chk("mem_q_drained", mem_q.size(), 0);
    chk("commit_q_drained", commit_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
